// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core front-end.
package mips_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned PC_STEP   = 4;

    localparam logic [WORD_SIZE-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [WORD_SIZE-1:0] NOP      = 32'h0000_0000;

    typedef enum logic {
        RUN,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch front-end: drives imem_addr from a register and presents a
// valid-tagged {pc, instruction} to decode, absorbing stalls and redirects.
module instruction_fetch #(
    parameter int unsigned           WORD_SIZE = mips_pkg::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0]  RESET_PC  = mips_pkg::RESET_PC,
    parameter int unsigned           PC_STEP   = mips_pkg::PC_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_instruction,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 if_valid,
    output logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] if_pc_plus4,
    output logic [WORD_SIZE-1:0] if_instruction
);
    import mips_pkg::*;

    localparam logic [WORD_SIZE-1:0] STEP       = WORD_SIZE'(PC_STEP);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(3);
    localparam logic [WORD_SIZE-1:0] ZERO_WORD  = WORD_SIZE'(NOP);

    fetch_state_t         state, state_next;
    logic [WORD_SIZE-1:0] pc, pc_next;
    logic [WORD_SIZE-1:0] rsp_pc, rsp_pc_next;
    logic                 rsp_valid, rsp_valid_next;
    logic [WORD_SIZE-1:0] hold_instr, hold_instr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            rsp_pc     <= RESET_PC;
            rsp_valid  <= 1'b0;
            hold_instr <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            rsp_pc     <= rsp_pc_next;
            rsp_valid  <= rsp_valid_next;
            hold_instr <= hold_instr_next;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        rsp_pc_next     = rsp_pc;
        rsp_valid_next  = rsp_valid;
        hold_instr_next = hold_instr;

        if (redirect_valid) begin
            // The word arriving next cycle belongs to the old pc, so the slot is squashed.
            pc_next         = redirect_pc & ALIGN_MASK;
            rsp_valid_next  = 1'b0;
            state_next      = RUN;
            hold_instr_next = '0;
        end else if (stall) begin
            // Capture the presented word; memory keeps reading pc, which is the next word.
            if (state == RUN && rsp_valid) begin
                hold_instr_next = imem_instruction;
                state_next      = HOLD;
            end
        end else begin
            rsp_pc_next    = pc;
            rsp_valid_next = 1'b1;
            pc_next        = pc + STEP;
            state_next     = RUN;
        end
    end

    assign imem_addr   = pc;
    assign if_valid    = rsp_valid;
    assign if_pc       = rsp_pc;
    assign if_pc_plus4 = rsp_pc + STEP;

    always_comb begin
        if_instruction = ZERO_WORD;
        if (rsp_valid) begin
            if_instruction = (state == HOLD) ? hold_instr : imem_instruction;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed test-plan scenarios plus
// randomized stall/redirect traffic checked against a transaction-level model.
module tb_instruction_fetch;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [W-1:0] redirect_pc = '0;
    logic [W-1:0] imem_instruction = '0;
    logic [W-1:0] imem_addr, if_pc, if_pc_plus4, if_instruction;
    logic         if_valid;

    int n_checks = 0;
    int n_fails  = 0;
    bit scramble = 1'b0;

    logic [W-1:0] prog [4] = '{32'h20010004, 32'h20020006, 32'h00221820, 32'h08000000};

    // Model: what decode should see, and the address the fetcher should be reading.
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_pc    = '0;
    logic [W-1:0] fetch_pc  = '0;

    instruction_fetch #(.WORD_SIZE(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_pc_plus4      (if_pc_plus4),
        .if_instruction   (if_instruction)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        if (scramble) return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
        if (a < 32'h10 && a[1:0] == 2'b00) return prog[a[3:2]];
        return '0;
    endfunction

    always @(posedge clk) imem_instruction <= mem_word(imem_addr);

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_pc    = '0;
        fetch_pc  = '0;
    endtask

    // Drive one cycle of inputs, update the model for that edge, sample 1ns after it.
    task automatic advance(input logic s, input logic r, input logic [W-1:0] rpc);
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rpc;
        if (r) begin
            exp_valid = 1'b0;
            fetch_pc  = rpc & ~32'h3;
        end else if (!s) begin
            exp_pc    = fetch_pc;
            exp_valid = 1'b1;
            fetch_pc  = fetch_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++; if (if_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        n_checks++; if (if_pc !== 32'h0) begin n_fails++; $display("FAIL reset_pc: got %h want 00000000", if_pc); end
        n_checks++; if (if_pc_plus4 !== 32'h4) begin n_fails++; $display("FAIL reset_pc_plus4: got %h want 00000004", if_pc_plus4); end
        n_checks++; if (if_instruction !== 32'h0) begin n_fails++; $display("FAIL reset_instr: got %h want 00000000", if_instruction); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential(input string tag);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] want_pc;
            want_pc = 32'(i * 4);
            advance(1'b0, 1'b0, '0);
            n_checks++; if (if_valid !== 1'b1) begin n_fails++; $display("FAIL %s_valid[%0d]: got %b want 1", tag, i, if_valid); end
            n_checks++; if (if_pc !== want_pc) begin n_fails++; $display("FAIL %s_pc[%0d]: got %h want %h", tag, i, if_pc, want_pc); end
            n_checks++; if (if_pc_plus4 !== want_pc + 32'd4) begin n_fails++; $display("FAIL %s_plus4[%0d]: got %h want %h", tag, i, if_pc_plus4, want_pc + 32'd4); end
            n_checks++; if (if_instruction !== prog[i]) begin n_fails++; $display("FAIL %s_instr[%0d]: got %h want %h", tag, i, if_instruction, prog[i]); end
            n_checks++; if (imem_addr !== want_pc + 32'd4) begin n_fails++; $display("FAIL %s_addr[%0d]: got %h want %h", tag, i, imem_addr, want_pc + 32'd4); end
        end
    endtask

    task automatic test_redirect();
        advance(1'b0, 1'b1, 32'h0);
        n_checks++; if (if_valid !== 1'b0) begin n_fails++; $display("FAIL redir_bubble_valid: got %b want 0", if_valid); end
        n_checks++; if (if_instruction !== 32'h0) begin n_fails++; $display("FAIL redir_bubble_instr: got %h want 00000000", if_instruction); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("FAIL redir_addr: got %h want 00000000", imem_addr); end
        advance(1'b0, 1'b0, '0);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_fails++; $display("FAIL redir_target: got valid=%b pc=%h want valid=1 pc=00000000", if_valid, if_pc); end
        n_checks++; if (if_instruction !== prog[0]) begin n_fails++; $display("FAIL redir_target_instr: got %h want %h", if_instruction, prog[0]); end
        advance(1'b0, 1'b0, '0);
        n_checks++; if (if_pc !== 32'h4 || if_instruction !== prog[1]) begin n_fails++; $display("FAIL redir_follow: got pc=%h instr=%h want pc=00000004 instr=%h", if_pc, if_instruction, prog[1]); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            advance(1'b1, 1'b0, '0);
            n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin n_fails++; $display("FAIL stall_pc[%0d]: got valid=%b pc=%h want valid=1 pc=00000004", i, if_valid, if_pc); end
            n_checks++; if (if_instruction !== prog[1]) begin n_fails++; $display("FAIL stall_instr[%0d]: got %h want %h", i, if_instruction, prog[1]); end
            n_checks++; if (imem_addr !== 32'h8) begin n_fails++; $display("FAIL stall_addr[%0d]: got %h want 00000008", i, imem_addr); end
        end
        advance(1'b0, 1'b0, '0);
        n_checks++; if (if_pc !== 32'h8 || if_instruction !== prog[2]) begin n_fails++; $display("FAIL stall_release: got pc=%h instr=%h want pc=00000008 instr=%h", if_pc, if_instruction, prog[2]); end
        n_checks++; if (imem_addr !== 32'hC) begin n_fails++; $display("FAIL stall_release_addr: got %h want 0000000c", imem_addr); end
    endtask

    task automatic test_redirect_in_hold();
        advance(1'b1, 1'b0, '0);
        n_checks++; if (if_pc !== 32'h8 || if_instruction !== prog[2]) begin n_fails++; $display("FAIL hold_enter: got pc=%h instr=%h want pc=00000008 instr=%h", if_pc, if_instruction, prog[2]); end
        advance(1'b1, 1'b1, 32'h6);
        n_checks++; if (if_valid !== 1'b0 || if_instruction !== 32'h0) begin n_fails++; $display("FAIL hold_redir_bubble: got valid=%b instr=%h want valid=0 instr=00000000", if_valid, if_instruction); end
        n_checks++; if (imem_addr !== 32'h4) begin n_fails++; $display("FAIL hold_redir_addr: got %h want 00000004", imem_addr); end
        advance(1'b0, 1'b0, '0);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instruction !== prog[1]) begin n_fails++; $display("FAIL hold_redir_target: got valid=%b pc=%h instr=%h want valid=1 pc=00000004 instr=%h", if_valid, if_pc, if_instruction, prog[1]); end
        advance(1'b0, 1'b0, '0);
        n_checks++; if (if_pc !== 32'h8 || if_instruction !== prog[2]) begin n_fails++; $display("FAIL hold_redir_follow: got pc=%h instr=%h want pc=00000008 instr=%h", if_pc, if_instruction, prog[2]); end
    endtask

    task automatic test_wrap();
        advance(1'b0, 1'b1, 32'hFFFF_FFFC);
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin n_fails++; $display("FAIL wrap_redir: got addr=%h valid=%b want addr=fffffffc valid=0", imem_addr, if_valid); end
        advance(1'b0, 1'b0, '0);
        n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin n_fails++; $display("FAIL wrap_pc: got valid=%b pc=%h want valid=1 pc=fffffffc", if_valid, if_pc); end
        n_checks++; if (if_pc_plus4 !== 32'h0) begin n_fails++; $display("FAIL wrap_plus4: got %h want 00000000", if_pc_plus4); end
        n_checks++; if (if_instruction !== 32'h0) begin n_fails++; $display("FAIL wrap_instr: got %h want 00000000", if_instruction); end
    endtask

    task automatic test_async_reset();
        advance(1'b0, 1'b0, '0);
        advance(1'b1, 1'b0, '0);
        n_checks++; if (if_pc !== 32'h0 || if_instruction !== prog[0]) begin n_fails++; $display("FAIL areset_hold: got pc=%h instr=%h want pc=00000000 instr=%h", if_pc, if_instruction, prog[0]); end
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (if_valid !== 1'b0) begin n_fails++; $display("FAIL areset_valid: got %b want 0", if_valid); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("FAIL areset_addr: got %h want 00000000", imem_addr); end
        n_checks++; if (if_instruction !== 32'h0) begin n_fails++; $display("FAIL areset_instr: got %h want 00000000", if_instruction); end
        #2;
        rst = 1'b0;
        model_reset();
        test_sequential("restart");
    endtask

    task automatic test_random();
        scramble = 1'b1;
        advance(1'b0, 1'b1, $urandom);
        for (int i = 0; i < 400; i++) begin
            logic         s, r;
            logic [W-1:0] rpc;
            s   = ($urandom % 10) < 3;
            r   = ($urandom % 10) == 0;
            rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
            advance(s, r, rpc);
            n_checks++; if (imem_addr !== fetch_pc) begin n_fails++; $display("FAIL rand_addr[%0d]: got %h want %h", i, imem_addr, fetch_pc); end
            n_checks++; if (if_valid !== exp_valid) begin n_fails++; $display("FAIL rand_valid[%0d]: got %b want %b", i, if_valid, exp_valid); end
            if (exp_valid) begin
                n_checks++; if (if_pc !== exp_pc) begin n_fails++; $display("FAIL rand_pc[%0d]: got %h want %h", i, if_pc, exp_pc); end
                n_checks++; if (if_pc_plus4 !== exp_pc + 32'd4) begin n_fails++; $display("FAIL rand_plus4[%0d]: got %h want %h", i, if_pc_plus4, exp_pc + 32'd4); end
                n_checks++; if (if_instruction !== mem_word(exp_pc)) begin n_fails++; $display("FAIL rand_instr[%0d]: got %h want %h", i, if_instruction, mem_word(exp_pc)); end
            end else begin
                n_checks++; if (if_instruction !== 32'h0) begin n_fails++; $display("FAIL rand_bubble_instr[%0d]: got %h want 00000000", i, if_instruction); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential("seq");
        test_redirect();
        test_stall();
        test_redirect_in_hold();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch front-end for the MIPS core. Drives the instruction memory address and consumes its 1-cycle-latency registered read data.
- Presents a valid-tagged {pc, instruction} to decode. Handles sequential PC+4, branch/jump redirects and decode-side stalls.
- Never drops or duplicates an instruction.

Parameters:
WORD_SIZE, 32, width of PC, address and instruction
RESET_PC, 32'h00000000, first fetch address after reset
PC_STEP, 4, sequential increment (byte addressing)

Ports:
clk  input  1  core clock, all state on posedge
rst  input  1  asynchronous, active-high reset
imem_addr  output  WORD_SIZE  address to instruction memory, sampled by the memory on posedge
imem_instruction  input  WORD_SIZE  memory read data; it is the word at the imem_addr sampled at the previous posedge
stall  input  1  decode cannot accept the current output this cycle
redirect_valid  input  1  branch/jump taken; squash in-flight fetch
redirect_pc  input  WORD_SIZE  redirect target
if_valid  output  1  if_pc/if_instruction hold a real instruction
if_pc  output  WORD_SIZE  address of if_instruction
if_pc_plus4  output  WORD_SIZE  if_pc + PC_STEP, combinational
if_instruction  output  WORD_SIZE  fetched word; 0 when if_valid=0

Behaviour:
- Registers:
  - pc: drives imem_addr directly, no combinational path.
  - rsp_pc, rsp_valid.
  - state ∈ {RUN, HOLD}.
  - hold_instr.
- Reset (async, immediate):
  - pc=RESET_PC, rsp_pc=RESET_PC, rsp_valid=0, state=RUN, hold_instr=0.
  - Outputs: imem_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_pc_plus4=RESET_PC+4, if_instruction=0.
- Output mux:
  - if_instruction = !rsp_valid ? 0 : (state==HOLD ? hold_instr : imem_instruction).
  - if_pc = rsp_pc; if_valid = rsp_valid.
- Per-edge priority, highest first:
  1. redirect_valid: pc<=redirect_pc with bits[1:0] forced 0; rsp_valid<=0; state<=RUN; the held word is discarded. The word returned next cycle belongs to the old pc and is squashed.
  2. stall, state RUN, rsp_valid=1: hold_instr<=imem_instruction; state<=HOLD; pc and rsp_pc unchanged. The memory keeps reading pc, which is exactly the next word.
  3. stall, state RUN, rsp_valid=0: nothing changes; a bubble stays a bubble.
  4. stall, state HOLD: nothing changes.
  5. no stall (RUN or HOLD): rsp_pc<=pc; rsp_valid<=1; pc<=pc+PC_STEP; state<=RUN.
- Latency:
  - First valid output 1 cycle after reset release.
  - Redirect → 1 bubble cycle, then if_pc=target.
  - Throughput 1 instruction/cycle without stall.
- Arithmetic:
  - Modulo 2^WORD_SIZE; 0xFFFFFFFC+4 wraps to 0. No overflow flag.
  - if_pc_plus4 computed the same way.
- Decode samples the output on every edge where if_valid=1 and stall=0. Each fetched pc appears exactly once in that sampled stream.
- imem_instruction is unused while state=HOLD.
- stall is never combinationally routed to imem_addr.

Decomposition:
- Shared package mips_pkg:
  - WORD_SIZE, PC_STEP and RESET_PC constants.
  - fetch_state_t enum {RUN, HOLD}.
  - NOP constant 32'h00000000.
- Single module; no sub-module warranted. The hold register is too small to split out.

Test Plan:
Program under test: 0x0 → 0x20010004, 0x4 → 0x20020006, 0x8 → 0x00221820, 0xC → 0x08000000; every other address returns 0.
1. Release rst, no stall/redirect → cycle0 if_valid=0, imem_addr=0; then (if_pc, if_instruction) = (0,0x20010004), (4,0x20020006), (8,0x00221820), (C,0x08000000) on consecutive cycles; if_pc_plus4 = if_pc+4.
2. Assert stall 3 cycles while if_pc=4 → if_pc=4 and if_instruction=0x20020006 held every cycle, imem_addr=8 throughout; after release next accepted is (8,0x00221820), no skip, no duplicate.
3. redirect_valid=1, redirect_pc=0 while if_pc=C → next cycle if_valid=0, if_instruction=0; following cycle (0,0x20010004).
4. redirect and stall both asserted in HOLD → redirect wins: bubble, then (redirect_pc, word) with HOLD exited. redirect_pc=0x6 → fetch from 0x4.
5. redirect_pc=0xFFFFFFFC → imem_addr 0xFFFFFFFC then 0x00000000; if_pc=0xFFFFFFFC with if_pc_plus4=0, instruction 0.
6. Assert rst mid-HOLD, asynchronously between edges → if_valid=0, imem_addr=0, if_instruction=0 immediately; after release, sequence of test 1 restarts.
